// File: rtl/demux_serializer.sv
// Serialises MST_DWIDTH-bit words into SYS_DWIDTH-bit beats and routes them
// to one of NUM_CH decryption-core inputs.
module demux_serializer #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8,
    parameter int NUM_CH     = 3,
    parameter int SEL_W      = 2,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                         clk_sys,
    input  logic                         rst,
    input  logic [SEL_W-1:0]             select,
    input  logic [MST_DWIDTH-1:0]        data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]            valid_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int BEATS = MST_DWIDTH / SYS_DWIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [MST_DWIDTH-1:0]         shreg_q, shreg_d;
    logic [SEL_W-1:0]              ch_q, ch_d;
    logic [NUM_CH*SYS_DWIDTH-1:0]  data_q, data_d;
    logic [NUM_CH-1:0]             valid_q, valid_d;
    logic                          err_q, err_d;

    logic                          last;
    logic                          accept;
    logic                          sel_ok;
    logic                          emit;
    logic [SYS_DWIDTH-1:0]         beat;

    function automatic logic [SYS_DWIDTH-1:0] beat_of(
        input logic [MST_DWIDTH-1:0] w
    );
        if (MSB_FIRST) return w[MST_DWIDTH-1 -: SYS_DWIDTH];
        else           return w[SYS_DWIDTH-1:0];
    endfunction

    // Moves the next beat into the position beat_of() reads from.
    function automatic logic [MST_DWIDTH-1:0] shift_of(
        input logic [MST_DWIDTH-1:0] w
    );
        if (MSB_FIRST) return w << SYS_DWIDTH;
        else           return w >> SYS_DWIDTH;
    endfunction

    assign last    = (state_q == SHIFT) && (cnt_q == CNT_W'(BEATS - 1));
    assign ready_o = (state_q == IDLE) || last;
    assign accept  = valid_i && ready_o;
    assign sel_ok  = 32'(select) < 32'(NUM_CH);

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q == SHIFT);
    assign err_o   = err_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && sel_ok && (BEATS > 1)) state_d = SHIFT;
            end
            SHIFT: begin
                if (!last) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = (accept && sel_ok) ? SHIFT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        ch_d    = ch_q;
        err_d   = 1'b0;
        emit    = 1'b0;
        beat    = '0;
        data_d  = '0;
        valid_d = '0;
        if (accept) begin
            if (sel_ok) begin
                shreg_d = shift_of(data_i);
                ch_d    = select;
                beat    = beat_of(data_i);
                emit    = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if ((state_q == SHIFT) && !last) begin
            shreg_d = shift_of(shreg_q);
            beat    = beat_of(shreg_q);
            emit    = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (emit && (ch_d == SEL_W'(c))) begin
                data_d[c*SYS_DWIDTH +: SYS_DWIDTH] = beat;
                valid_d[c]                         = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_serializer.sv
// Directed bench for demux_serializer: default 32/8 MSB-first, 64/8
// LSB-first with four channels, and the single-beat configuration.
module tb_demux_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [1:0]  sel_a;
    logic [31:0] din_a;
    logic        vin_a, ready_a, busy_a, err_a;
    logic [23:0] dout_a;
    logic [2:0]  vout_a;

    logic [1:0]  sel_b;
    logic [63:0] din_b;
    logic        vin_b, ready_b, busy_b, err_b;
    logic [31:0] dout_b;
    logic [3:0]  vout_b;

    logic [1:0]  sel_c;
    logic [7:0]  din_c;
    logic        vin_c, ready_c, busy_c, err_c;
    logic [23:0] dout_c;
    logic [2:0]  vout_c;

    demux_serializer #(
        .MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3),
        .SEL_W(2), .MSB_FIRST(1'b1)
    ) u_a (
        .clk_sys(clk), .rst(rst), .select(sel_a), .data_i(din_a),
        .valid_i(vin_a), .ready_o(ready_a), .data_o(dout_a),
        .valid_o(vout_a), .busy_o(busy_a), .err_o(err_a)
    );

    demux_serializer #(
        .MST_DWIDTH(64), .SYS_DWIDTH(8), .NUM_CH(4),
        .SEL_W(2), .MSB_FIRST(1'b0)
    ) u_b (
        .clk_sys(clk), .rst(rst), .select(sel_b), .data_i(din_b),
        .valid_i(vin_b), .ready_o(ready_b), .data_o(dout_b),
        .valid_o(vout_b), .busy_o(busy_b), .err_o(err_b)
    );

    demux_serializer #(
        .MST_DWIDTH(8), .SYS_DWIDTH(8), .NUM_CH(3),
        .SEL_W(2), .MSB_FIRST(1'b1)
    ) u_c (
        .clk_sys(clk), .rst(rst), .select(sel_c), .data_i(din_c),
        .valid_i(vin_c), .ready_o(ready_c), .data_o(dout_c),
        .valid_o(vout_c), .busy_o(busy_c), .err_o(err_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Beat b on channel ch of instance A, or all-quiet when v is 0.
    task automatic chk_a(input string tag, input int ch,
                         input logic [7:0] b, input logic v);
        logic [23:0] ed;
        logic [2:0]  ev;
        ed = v ? (24'(b) << (8 * ch)) : 24'h0;
        ev = v ? (3'b001 << ch) : 3'b000;
        check({tag, " data"}, 64'(dout_a), 64'(ed));
        check({tag, " valid"}, 64'(vout_a), 64'(ev));
    endtask

    logic [7:0] exp2  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] exp3a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp3b [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] exp5  [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    logic [7:0] exp6  [8] = '{8'h08, 8'h07, 8'h06, 8'h05,
                              8'h04, 8'h03, 8'h02, 8'h01};

    initial begin
        rst = 1'b0;
        sel_a = '0; din_a = '0; vin_a = 1'b0;
        sel_b = '0; din_b = '0; vin_b = 1'b0;
        sel_c = '0; din_c = '0; vin_c = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_a("rst", 0, 8'h00, 1'b0);
        check("rst busy", 64'(busy_a), 64'd0);
        check("rst err", 64'(err_a), 64'd0);
        check("rst b valid", 64'(vout_b), 64'd0);
        step;
        step;
        rst = 1'b0;
        check("rel ready", 64'(ready_a), 64'd1);
        step;

        // single word, channel 0, MSB first
        sel_a = 2'd0; din_a = 32'hA1B2C3D4; vin_a = 1'b1;
        check("t2 ready", 64'(ready_a), 64'd1);
        step;
        vin_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_a("t2 beat", 0, exp2[k], 1'b1);
            check("t2 busy", 64'(busy_a), 64'd1);
            step;
        end
        chk_a("t2 idle", 0, 8'h00, 1'b0);
        check("t2 idle busy", 64'(busy_a), 64'd0);

        // back-to-back, second word held until the last beat takes it
        sel_a = 2'd1; din_a = 32'h11223344; vin_a = 1'b1;
        step;
        sel_a = 2'd2; din_a = 32'h55667788;
        for (int k = 0; k < 4; k++) begin
            chk_a("t3 w1", 1, exp3a[k], 1'b1);
            check("t3 ready", 64'(ready_a), 64'(k == 3));
            step;
        end
        vin_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_a("t3 w2", 2, exp3b[k], 1'b1);
            step;
        end
        chk_a("t3 idle", 0, 8'h00, 1'b0);

        // bad select
        sel_a = 2'd3; din_a = 32'hDEADBEEF; vin_a = 1'b1;
        check("t4 ready", 64'(ready_a), 64'd1);
        step;
        vin_a = 1'b0;
        check("t4 err", 64'(err_a), 64'd1);
        chk_a("t4 quiet", 0, 8'h00, 1'b0);
        check("t4 ready after", 64'(ready_a), 64'd1);
        check("t4 busy", 64'(busy_a), 64'd0);
        step;
        check("t4 err drop", 64'(err_a), 64'd0);
        chk_a("t4 quiet2", 0, 8'h00, 1'b0);

        // reset mid-word
        sel_a = 2'd0; din_a = 32'hCAFEF00D; vin_a = 1'b1;
        step;
        vin_a = 1'b0;
        chk_a("t5 beat0", 0, 8'hCA, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_a("t5 async", 0, 8'h00, 1'b0);
        check("t5 async busy", 64'(busy_a), 64'd0);
        step;
        step;
        chk_a("t5 held", 0, 8'h00, 1'b0);
        rst = 1'b0;
        check("t5 rel ready", 64'(ready_a), 64'd1);
        step;
        chk_a("t5 no tail", 0, 8'h00, 1'b0);
        sel_a = 2'd1; din_a = 32'h0A0B0C0D; vin_a = 1'b1;
        step;
        vin_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_a("t5 new", 1, exp5[k], 1'b1);
            step;
        end
        chk_a("t5 idle", 0, 8'h00, 1'b0);

        // 64-bit LSB first to channel 3
        sel_b = 2'd3; din_b = 64'h0102030405060708; vin_b = 1'b1;
        check("t6 ready", 64'(ready_b), 64'd1);
        step;
        vin_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t6 data", 64'(dout_b), 64'({exp6[k], 24'h0}));
            check("t6 valid", 64'(vout_b), 64'd8);
            check("t6 ready", 64'(ready_b), 64'(k == 7));
            step;
        end
        check("t6 idle valid", 64'(vout_b), 64'd0);
        check("t6 idle data", 64'(dout_b), 64'd0);
        check("t6 idle busy", 64'(busy_b), 64'd0);

        // single-beat words
        check("t7 ready", 64'(ready_c), 64'd1);
        sel_c = 2'd2; din_c = 8'h5A; vin_c = 1'b1;
        step;
        check("t7 data0", 64'(dout_c), 64'h5A0000);
        check("t7 valid0", 64'(vout_c), 64'd4);
        check("t7 ready0", 64'(ready_c), 64'd1);
        check("t7 busy0", 64'(busy_c), 64'd0);
        sel_c = 2'd0; din_c = 8'hC3;
        step;
        vin_c = 1'b0;
        check("t7 data1", 64'(dout_c), 64'h0000C3);
        check("t7 valid1", 64'(vout_c), 64'd1);
        step;
        check("t7 idle data", 64'(dout_c), 64'd0);
        check("t7 idle valid", 64'(vout_c), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
